// File: rtl/ft245_pkg.sv
// Shared definitions for the FT2232H synchronous 245-FIFO host.
//   - state_t      : controller state encoding (3 bits)
//   - BUS_W        : width of the shared data bus
//   - STROBE_ON/OFF: pin levels for the active-low strobes
package ft245_pkg;

    localparam int unsigned BUS_W = 8;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_OE     = 3'd1,
        RD_STROBE = 3'd2,
        RD_GAP    = 3'd3,
        WR_DRIVE  = 3'd4,
        WR_STROBE = 3'd5,
        WR_HOLD   = 3'd6
    } state_t;

    // Map "strobe asserted" onto the active-low pin level.
    function automatic logic strobe_level(input logic active);
        return active ? STROBE_ON : STROBE_OFF;
    endfunction

endpackage

// File: rtl/ft245_rx_fifo.sv
// Synchronous byte FIFO buffering USB->FPGA data.
// Ports:
//   in_clk, in_rst_n : clock, async active-low reset
//   push, wr_data    : write a byte (ignored when full unless popping too)
//   pop, rd_data     : remove the head byte; rd_data is the registered head
//   full, empty      : registered occupancy flags
//   free_cnt         : registered number of free slots
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ft245_rx_fifo
    import ft245_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  push,
    input  logic [BUS_W-1:0]      wr_data,
    input  logic                  pop,
    output logic [BUS_W-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   free_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    logic [BUS_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [PW-1:0]    used_nxt;
    logic [BUS_W-1:0] head_nxt;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign wr_ptr_nxt = wr_ptr + PW'(push_ok);
    assign rd_ptr_nxt = rd_ptr + PW'(pop_ok);
    assign used_nxt   = wr_ptr_nxt - rd_ptr_nxt;

    // Next head: bypass the incoming byte when it lands on the new read slot.
    always_comb begin
        head_nxt = mem[rd_ptr_nxt[DEPTH_LOG2-1:0]];
        if (push_ok && (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr_nxt[DEPTH_LOG2-1:0])) begin
            head_nxt = wr_data;
        end
    end

    // Storage array (no reset needed; contents are qualified by the pointers).
    always_ff @(posedge in_clk) begin
        if (push_ok) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Pointers, registered head and occupancy flags.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            free_cnt <= PW'(DEPTH);
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            rd_data  <= head_nxt;
            empty    <= (used_nxt == '0);
            full     <= (used_nxt == PW'(DEPTH));
            free_cnt <= PW'(DEPTH) - used_nxt;
        end
    end

endmodule

// File: rtl/ft245_sync_host.sv
// FPGA-side master for the FT2232H synchronous 245-FIFO interface.
// Converts the half-duplex pin protocol into two valid/ready byte streams.
// Ports:
//   in_clk, in_rst_n           : FT2232H CLKOUT, async active-low reset
//   in_rxf_n, in_txe_n         : device flags (synchronous to in_clk)
//   out_rd_n, out_wr_n, out_oe_n : registered active-low pin strobes
//   io_data                    : shared bus, driven only in write states
//   out_rx_data/valid, in_rx_ready : USB->FPGA stream
//   in_tx_data/valid, out_tx_ready : FPGA->USB stream (1-byte holding register)
//   out_busy                   : controller not idle
module ft245_sync_host
    import ft245_pkg::*;
#(
    parameter int unsigned RX_FIFO_DEPTH_LOG2 = 2
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_rxf_n,
    input  logic             in_txe_n,
    output logic             out_rd_n,
    output logic             out_wr_n,
    output logic             out_oe_n,
    inout  logic [BUS_W-1:0] io_data,
    output logic [BUS_W-1:0] out_rx_data,
    output logic             out_rx_valid,
    input  logic             in_rx_ready,
    input  logic [BUS_W-1:0] in_tx_data,
    input  logic             in_tx_valid,
    output logic             out_tx_ready,
    output logic             out_busy
);

    state_t                  state;
    state_t                  state_nxt;
    logic [BUS_W-1:0]        tx_q;
    logic                    tx_empty;
    logic                    tx_accept;
    logic                    wr_ok;
    logic                    drive_en;
    logic                    rx_push;
    logic                    rx_full;
    logic                    rx_empty;
    logic [RX_FIFO_DEPTH_LOG2:0] rx_free;

    // Byte is latched from the bus at the closing edge of a strobe the device honoured.
    assign rx_push   = (state == RD_STROBE) && !in_rxf_n;
    assign tx_accept = in_tx_valid && tx_empty;

    ft245_rx_fifo #(
        .DEPTH_LOG2 (RX_FIFO_DEPTH_LOG2)
    ) u_rx_fifo (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .push     (rx_push),
        .wr_data  (io_data),
        .pop      (in_rx_ready),
        .rd_data  (out_rx_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .free_cnt (rx_free)
    );

    assign out_rx_valid = !rx_empty;
    assign out_tx_ready = tx_empty;

    // Bus enable is a registered state decode, disjoint from the OE# decode.
    assign io_data = drive_en ? tx_q : {BUS_W{1'bz}};

    // State register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; reads win arbitration, direction changes go via IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!in_rxf_n && !rx_full) begin
                    state_nxt = RD_OE;
                end else if (!in_txe_n && !tx_empty) begin
                    state_nxt = WR_DRIVE;
                end
            end
            RD_OE:     state_nxt = RD_STROBE;
            RD_STROBE: state_nxt = RD_GAP;
            // rx_free already reflects the push made at the end of RD_STROBE.
            RD_GAP: begin
                if (!in_rxf_n && (rx_free != '0)) begin
                    state_nxt = RD_STROBE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR_DRIVE:  state_nxt = WR_STROBE;
            WR_STROBE: state_nxt = WR_HOLD;
            WR_HOLD:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Pin outputs registered from the next-state decode so they align with state.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_oe_n <= STROBE_OFF;
            out_rd_n <= STROBE_OFF;
            out_wr_n <= STROBE_OFF;
            drive_en <= 1'b0;
            out_busy <= 1'b0;
        end else begin
            out_oe_n <= strobe_level((state_nxt == RD_OE) || (state_nxt == RD_STROBE) ||
                                     (state_nxt == RD_GAP));
            out_rd_n <= strobe_level(state_nxt == RD_STROBE);
            out_wr_n <= strobe_level(state_nxt == WR_STROBE);
            drive_en <= (state_nxt == WR_DRIVE) || (state_nxt == WR_STROBE) ||
                        (state_nxt == WR_HOLD);
            out_busy <= (state_nxt != IDLE);
        end
    end

    // TX holding register; emptied only after the device confirmed the write.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            tx_q     <= '0;
            tx_empty <= 1'b1;
            wr_ok    <= 1'b0;
        end else begin
            if (state == WR_STROBE) begin
                wr_ok <= !in_txe_n;
            end
            if (tx_accept) begin
                tx_q     <= in_tx_data;
                tx_empty <= 1'b0;
            end else if ((state == WR_HOLD) && wr_ok) begin
                tx_empty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ft245_sync_host.sv
// Directed testbench for ft245_sync_host with a behavioural FT2232H FIFO model
// and RX/TX scoreboards.
module tb_ft245_sync_host;

    logic       in_clk;
    logic       in_rst_n;
    logic       in_rxf_n;
    logic       in_txe_n;
    logic       out_rd_n;
    logic       out_wr_n;
    logic       out_oe_n;
    wire  [7:0] io_data;
    logic [7:0] out_rx_data;
    logic       out_rx_valid;
    logic       in_rx_ready;
    logic [7:0] in_tx_data;
    logic       in_tx_valid;
    logic       out_tx_ready;
    logic       out_busy;

    int total = 0;
    int bad   = 0;

    // Device model: byte array with read/write indices.
    logic [7:0] dev_mem [64];
    int         dev_rd = 0;
    int         dev_wr = 0;

    logic [7:0] rx_exp [$];
    logic [7:0] tx_exp [$];

    int   rd_cnt    = 0;
    int   wr_cnt    = 0;
    int   wr_rdcnt  = 0;
    logic prev_rd   = 1'b1;
    int   base;

    ft245_sync_host #(.RX_FIFO_DEPTH_LOG2(2)) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_rxf_n     (in_rxf_n),
        .in_txe_n     (in_txe_n),
        .out_rd_n     (out_rd_n),
        .out_wr_n     (out_wr_n),
        .out_oe_n     (out_oe_n),
        .io_data      (io_data),
        .out_rx_data  (out_rx_data),
        .out_rx_valid (out_rx_valid),
        .in_rx_ready  (in_rx_ready),
        .in_tx_data   (in_tx_data),
        .in_tx_valid  (in_tx_valid),
        .out_tx_ready (out_tx_ready),
        .out_busy     (out_busy)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    assign in_rxf_n = (dev_rd == dev_wr);
    assign io_data  = out_oe_n ? 8'hzz : dev_mem[dev_rd[5:0]];

    // Device advances its read index when it sees RD# low with data available.
    always @(posedge in_clk) begin
        if (in_rst_n && !out_rd_n && !in_rxf_n) begin
            dev_rd <= dev_rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: scoreboards and pin-protocol rules.
    always @(negedge in_clk) begin
        if (in_rst_n) begin
            if (out_rx_valid && in_rx_ready) begin
                chk("rx_pending", 32'(rx_exp.size() > 0), 32'd1);
                if (rx_exp.size() > 0) begin
                    chk("rx_byte", 32'(out_rx_data), 32'(rx_exp.pop_front()));
                end
            end
            if (!out_wr_n) begin
                wr_cnt++;
                if (!in_txe_n) begin
                    chk("tx_pending", 32'(tx_exp.size() > 0), 32'd1);
                    if (tx_exp.size() > 0) begin
                        chk("tx_byte", 32'(io_data), 32'(tx_exp.pop_front()));
                    end
                    wr_rdcnt = rd_cnt;
                end
            end
            if (!out_rd_n) begin
                rd_cnt++;
                chk("rd_gap", 32'(prev_rd), 32'd1);
            end
            prev_rd = out_rd_n;
            chk("rd_wr_excl", 32'(!out_rd_n && !out_wr_n), 32'd0);
            chk("oe_wr_excl", 32'(!out_oe_n && !out_wr_n), 32'd0);
        end else begin
            prev_rd = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic dev_push(input logic [7:0] b);
        dev_mem[dev_wr[5:0]] = b;
        rx_exp.push_back(b);
        dev_wr++;
    endtask

    initial begin
        in_rst_n    = 1'b0;
        in_txe_n    = 1'b1;
        in_rx_ready = 1'b1;
        in_tx_valid = 1'b0;
        in_tx_data  = 8'h00;
        dev_push(8'h11);
        dev_push(8'h22);
        dev_push(8'h33);

        // Reset values with data pending at the device.
        #12;
        chk("rst_rd_n", 32'(out_rd_n), 32'd1);
        chk("rst_wr_n", 32'(out_wr_n), 32'd1);
        chk("rst_oe_n", 32'(out_oe_n), 32'd1);
        chk("rst_rx_valid", 32'(out_rx_valid), 32'd0);
        chk("rst_rx_data", 32'(out_rx_data), 32'd0);
        chk("rst_tx_ready", 32'(out_tx_ready), 32'd1);
        chk("rst_busy", 32'(out_busy), 32'd0);

        // Release: OE# on cycle 1, RD# on cycle 2, three pulses total.
        @(posedge in_clk); #1;
        in_rst_n = 1'b1;
        tick(1);
        chk("c1_oe_n", 32'(out_oe_n), 32'd0);
        chk("c1_rd_n", 32'(out_rd_n), 32'd1);
        chk("c1_busy", 32'(out_busy), 32'd1);
        tick(1);
        chk("c2_rd_n", 32'(out_rd_n), 32'd0);
        tick(10);
        chk("rd3_pulses", 32'(rd_cnt), 32'd3);
        chk("rd3_drained", 32'(rx_exp.size()), 32'd0);
        chk("rd3_oe_n", 32'(out_oe_n), 32'd1);
        chk("rd3_busy", 32'(out_busy), 32'd0);

        // Back-pressure: six bytes pending, consumer stalled.
        in_rx_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) dev_push(8'h40 + 8'(i));
        tick(16);
        chk("bp_pulses", 32'(rd_cnt), 32'd4);
        chk("bp_oe_n", 32'(out_oe_n), 32'd1);
        chk("bp_busy", 32'(out_busy), 32'd0);
        chk("bp_valid", 32'(out_rx_valid), 32'd1);
        chk("bp_head", 32'(out_rx_data), 32'h40);
        in_rx_ready = 1'b1;
        tick(20);
        chk("bp_drained", 32'(rx_exp.size()), 32'd0);
        chk("bp_resume_pulses", 32'(rd_cnt), 32'd6);

        // Single write, device ready throughout.
        in_txe_n = 1'b0;
        base = wr_cnt;
        tx_exp.push_back(8'hA5);
        in_tx_data  = 8'hA5;
        in_tx_valid = 1'b1;
        tick(1);
        in_tx_valid = 1'b0;
        chk("wr_accept_ready", 32'(out_tx_ready), 32'd0);
        tick(1);
        chk("wr_drive_wr_n", 32'(out_wr_n), 32'd1);
        chk("wr_drive_data", 32'(io_data), 32'hA5);
        chk("wr_drive_busy", 32'(out_busy), 32'd1);
        tick(1);
        chk("wr_strobe_wr_n", 32'(out_wr_n), 32'd0);
        chk("wr_strobe_data", 32'(io_data), 32'hA5);
        chk("wr_strobe_oe_n", 32'(out_oe_n), 32'd1);
        tick(1);
        chk("wr_hold_wr_n", 32'(out_wr_n), 32'd1);
        chk("wr_hold_data", 32'(io_data), 32'hA5);
        chk("wr_hold_ready", 32'(out_tx_ready), 32'd0);
        tick(1);
        chk("wr_done_ready", 32'(out_tx_ready), 32'd1);
        chk("wr_done_busy", 32'(out_busy), 32'd0);
        chk("wr_pulses", 32'(wr_cnt - base), 32'd1);
        chk("wr_sent", 32'(tx_exp.size()), 32'd0);

        // Device not ready during the strobe: byte retained, then resent.
        tx_exp.push_back(8'hA5);
        in_tx_data  = 8'hA5;
        in_tx_valid = 1'b1;
        tick(1);
        in_tx_valid = 1'b0;
        tick(1);
        in_txe_n = 1'b1;
        tick(1);
        chk("retry_strobe_wr_n", 32'(out_wr_n), 32'd0);
        tick(3);
        chk("retry_ready", 32'(out_tx_ready), 32'd0);
        chk("retry_busy", 32'(out_busy), 32'd0);
        chk("retry_retained", 32'(tx_exp.size()), 32'd1);
        in_txe_n = 1'b0;
        tick(6);
        chk("retry_sent", 32'(tx_exp.size()), 32'd0);
        chk("retry_done_ready", 32'(out_tx_ready), 32'd1);

        // Read and write pending together: read completes first.
        base = rd_cnt;
        tx_exp.push_back(8'h5A);
        in_tx_data  = 8'h5A;
        in_tx_valid = 1'b1;
        dev_push(8'h77);
        dev_push(8'h88);
        tick(1);
        in_tx_valid = 1'b0;
        chk("arb_read_first", 32'(out_oe_n), 32'd0);
        chk("arb_tx_held", 32'(out_tx_ready), 32'd0);
        tick(12);
        chk("arb_rx_done", 32'(rx_exp.size()), 32'd0);
        chk("arb_tx_done", 32'(tx_exp.size()), 32'd0);
        chk("arb_order", 32'(wr_rdcnt), 32'(base + 2));

        // Asynchronous reset in the middle of a write strobe.
        in_tx_data  = 8'h3C;
        in_tx_valid = 1'b1;
        tick(1);
        in_tx_valid = 1'b0;
        tick(2);
        chk("arst_pre_wr_n", 32'(out_wr_n), 32'd0);
        in_rst_n = 1'b0;
        #1;
        chk("arst_wr_n", 32'(out_wr_n), 32'd1);
        chk("arst_oe_n", 32'(out_oe_n), 32'd1);
        chk("arst_tx_ready", 32'(out_tx_ready), 32'd1);
        chk("arst_busy", 32'(out_busy), 32'd0);
        tick(2);
        in_rst_n = 1'b1;
        tick(5);
        chk("arst_idle_busy", 32'(out_busy), 32'd0);
        chk("arst_idle_ready", 32'(out_tx_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ft245_sync_host.md
# ft245_sync_host

FPGA-side master for the FT2232H synchronous 245-FIFO interface: the controller that drives RD#/WR#/OE# against the FT2232H's RXF#/TXE# flags and the shared 8-bit data bus. It sits between the board pins (or the FT2232H device model in simulation) and on-chip logic. It converts the half-duplex pin protocol into two byte streams with valid/ready handshakes: USB→FPGA bytes out, FPGA→USB bytes in. The block is clocked by the FT2232H 60 MHz output clock.

## Interface
- RX_FIFO_DEPTH_LOG2, 2: log2 of the RX byte buffer depth (4 entries).
- in_clk  input  1  FT2232H CLKOUT; all logic on its rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_rxf_n  input  1  low: the device has data for the FPGA.
- in_txe_n  input  1  low: the device can accept data from the FPGA.
- out_rd_n  output  1  read strobe, active low.
- out_wr_n  output  1  write strobe, active low.
- out_oe_n  output  1  low: the device drives io_data.
- io_data  inout  8  shared data bus; the block drives it only in write states.
- out_rx_data  output  8  head byte of the RX buffer.
- out_rx_valid  output  1  RX buffer not empty.
- in_rx_ready  input  1  consumer pops the head when valid and ready are both high.
- in_tx_data  input  8  byte to send.
- in_tx_valid  input  1  a byte is offered.
- out_tx_ready  output  1  the byte is accepted on a cycle where valid and ready are both high.
- out_busy  output  1  state is not IDLE.

## Operation
- States: IDLE, RD_OE, RD_STROBE, RD_GAP, WR_DRIVE, WR_STROBE, WR_HOLD.
- Arbitration in IDLE. Read wins when in_rxf_n=0 and the RX buffer has at least 1 free slot. Otherwise, write when in_txe_n=0 and the TX holding register is full.
- TX holding register: 1 byte. out_tx_ready = register empty. The register is loaded on valid&ready and cleared only after a confirmed write.
- IDLE→RD_OE: OE#=0, no strobe (bus turnaround).
- RD_OE→RD_STROBE: RD#=0.
- RD_STROBE→RD_GAP: at the closing edge, io_data is pushed into the RX buffer only if in_rxf_n=0 during the RD_STROBE cycle; otherwise the byte is discarded.
- In RD_GAP: RD#=1 and OE# stays 0.
  - Go to RD_STROBE if in_rxf_n=0 and a slot is free, counting the push just made.
  - Otherwise go to IDLE and deassert OE#.
- IDLE→WR_DRIVE: io_data driven from the holding register, WR#=1.
- WR_DRIVE→WR_STROBE: WR#=0.
- WR_STROBE→WR_HOLD: WR#=1, data still driven. The write is confirmed if in_txe_n=0 during the WR_STROBE cycle.
- In WR_HOLD:
  - if confirmed, clear the register and go to IDLE (bus released);
  - if not confirmed, go to IDLE with the byte retained and retry later.
- Rules: the block never drives io_data while OE#=0. RD# and WR# are never low simultaneously. Every read↔write direction change passes through IDLE.
- RX buffer: a simultaneous push and pop in one cycle is allowed, including when the buffer is full. No push is made when the buffer is full; that is prevented by the arbitration.

## Timing
- Reset values:
  - RD#=WR#=OE#=1;
  - io_data hi-Z;
  - out_rx_valid=0, out_rx_data=0;
  - out_tx_ready=1, out_busy=0;
  - state IDLE;
  - RX buffer and TX register empty.
- A reset assertion mid-transfer returns every output to its reset value immediately (asynchronous). Partial bytes are lost.
- All pin outputs are registered. The data-bus enable is a registered state decode.
- Read latency: RD_OE is 1 cycle. Then each byte costs 2 cycles (STROBE + GAP), i.e. 1 byte per 2 cycles sustained.
- A pushed byte appears on out_rx_data/out_rx_valid 1 cycle after the RD_STROBE edge.
- Write latency: 3 cycles per byte (DRIVE, STROBE, HOLD) plus 1 IDLE cycle. out_tx_ready rises 1 cycle after WR_HOLD.
- in_rxf_n and in_txe_n are synchronous to in_clk; the block has no synchronizers.

## Structure
- Package ft245_pkg holds:
  - the state enumeration (3-bit encoding);
  - the bus width constant (8);
  - the strobe-level constants STROBE_ON=0 and STROBE_OFF=1.
- Sub-module ft245_rx_fifo: synchronous FIFO with a DEPTH_LOG2 parameter. Ports: push, pop, data in/out, full, empty, free count. Pointers carry one extra wrap bit.
- The top level holds the FSM, the TX holding register and the tri-state assignment.

## Test plan
- Reset with in_rxf_n=0: all outputs at their reset values. After release, OE#=0 on cycle 1 and RD#=0 on cycle 2.
- Device offers 0x11, 0x22, 0x33 with in_rx_ready=1 → out_rx_data delivers 0x11, 0x22, 0x33 in order. There are exactly 3 RD# pulses, each 1 cycle low with a 1-cycle gap.
- in_rx_ready=0 with 6 bytes pending → exactly 4 RD# pulses, then OE#=1 and IDLE. Raising in_rx_ready drains 4 bytes and then resumes reading.
- TX 0xA5 with in_txe_n=0 → io_data=0xA5 for DRIVE/STROBE/HOLD, WR# low for 1 cycle, out_tx_ready=1 again 4 cycles after acceptance.
- in_txe_n=1 during WR_STROBE → byte retained, out_tx_ready stays 0. 0xA5 is re-sent once in_txe_n=0.
- in_rxf_n=0 and a TX byte pending simultaneously → the read completes first. The write starts only after IDLE, with no overlap of bus drive and OE#.
